writeback_unit: RTL

- MEM/WB write-back stage that drives the register file write port (write_reg_num1, write_data, reg_write).
- Accepts retiring instructions from the MEM stage over a valid/ready handshake and buffers them in order in a DEPTH-entry queue.
- Loads wait at the queue head for an in-order load response, and each entry is written exactly once.
- Exports a per-register pending-write vector to the hazard detection unit.

---
 rtl/wb_pkg.sv | 24 ++
 rtl/wb_fifo.sv | 79 +++++++
 rtl/writeback_unit.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared types for the MEM/WB write-back stage: write-back select codes,
// the queued entry layout and the head-of-queue state encoding.
package wb_pkg;

    localparam int unsigned WB_XLEN = 32;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_LOAD = 2'd1;
    localparam logic [1:0] WB_PC4  = 2'd2;

    typedef struct packed {
        logic [4:0]         rd;
        logic               reg_write;
        logic               is_load;
        logic [WB_XLEN-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        HEAD_RDY  = 2'd1,
        HEAD_WAIT = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_fifo.sv
// Generic in-order queue. Pointers carry one extra bit so full and empty
// are distinct. Besides the current head it exposes the head as it will be
// after this edge (push/pop applied), plus every slot and its valid bit.
module wb_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = logic [7:0]
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  T                 i_push_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output T                 o_head,
    output logic             o_nxt_empty,
    output T                 o_nxt_head,
    output logic [DEPTH-1:0] o_vld,
    output T                 o_ent [DEPTH]
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    T            r_mem [DEPTH];

    logic [AW:0] w_cnt;
    logic [AW:0] w_wr_nxt;
    logic [AW:0] w_rd_nxt;
    logic        w_push;
    logic        w_pop;

    assign w_cnt    = r_wr_ptr - r_rd_ptr;
    assign o_empty  = (r_wr_ptr == r_rd_ptr);
    assign o_full   = (w_cnt == (AW+1)'(DEPTH));
    assign w_push   = i_push && !o_full;
    assign w_pop    = i_pop && !o_empty;
    assign w_wr_nxt = r_wr_ptr + {{AW{1'b0}}, w_push};
    assign w_rd_nxt = r_rd_ptr + {{AW{1'b0}}, w_pop};
    assign o_head   = r_mem[r_rd_ptr[AW-1:0]];

    // When the next head slot is the one being written now, the data is
    // still on the push input rather than in storage.
    assign o_nxt_empty = (w_wr_nxt == w_rd_nxt);
    assign o_nxt_head  = (w_rd_nxt == r_wr_ptr) ? i_push_data
                                                : r_mem[w_rd_nxt[AW-1:0]];

    // Pointer update; reset discards every queued entry
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_wr_ptr <= w_wr_nxt;
            r_rd_ptr <= w_rd_nxt;
        end
    end

    // Entry storage; contents of free slots are don't-care
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
        end
    end

    // A slot is valid when its distance from the read pointer is below count
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            localparam logic [AW-1:0] IDX = AW'(gi);
            logic [AW-1:0] w_off;
            assign w_off      = IDX - r_rd_ptr[AW-1:0];
            assign o_vld[gi]  = ({1'b0, w_off} < w_cnt);
            assign o_ent[gi]  = r_mem[gi];
        end
    endgenerate

endmodule

// File: rtl/writeback_unit.sv
// MEM/WB write-back stage. Buffers retiring instructions in order, holds
// loads at the head until their in-order response arrives, and drives a
// registered register-file write port. busy_vec flags destinations that
// still have a queued write.
// Optional build macro WB_TRACE_EN: simulation trace of writes and protocol
// errors plus a hierarchically readable retire counter (r_retire_cnt).
module writeback_unit
    import wb_pkg::*;
#(
    parameter int XLEN  = WB_XLEN,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [4:0]      mem_rd,
    input  logic            mem_reg_write,
    input  logic [1:0]      mem_wb_sel,
    input  logic [XLEN-1:0] mem_alu_result,
    input  logic [XLEN-1:0] mem_pc_plus4,
    input  logic            load_rsp_valid,
    input  logic [XLEN-1:0] load_rsp_data,
    output logic [4:0]      write_reg_num1,
    output logic [XLEN-1:0] write_data,
    output logic            reg_write,
    output logic [31:0]     busy_vec,
    output logic            proto_err
);

    wb_entry_t        w_push_ent;
    wb_entry_t        w_head;
    wb_entry_t        w_nxt_head;
    wb_entry_t        w_ent [DEPTH];
    logic [DEPTH-1:0] w_vld;
    logic             w_full;
    logic             w_empty;
    logic             w_nxt_empty;
    logic             w_accept;
    logic             w_pop;
    logic [XLEN-1:0]  w_ret_data;
    logic [31:0]      w_busy;

    wb_state_e        r_state;
    wb_state_e        w_state_nxt;

    logic             r_reg_write;
    logic [4:0]       r_rd;
    logic [XLEN-1:0]  r_data;
    logic             r_proto_err;

    assign mem_ready = !w_full;
    assign w_accept  = mem_valid && mem_ready;

    // Build the queue entry; reserved select falls back to the ALU result
    always_comb begin
        w_push_ent           = '0;
        w_push_ent.rd        = mem_rd;
        w_push_ent.reg_write = mem_reg_write;
        w_push_ent.is_load   = (mem_wb_sel == WB_LOAD);
        w_push_ent.data      = (mem_wb_sel == WB_PC4) ? mem_pc_plus4 : mem_alu_result;
    end

    wb_fifo #(
        .DEPTH (DEPTH),
        .T     (wb_entry_t)
    ) u_fifo (
        .i_clk       (clk),
        .i_rst_n     (rst),
        .i_push      (w_accept),
        .i_push_data (w_push_ent),
        .i_pop       (w_pop),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_head      (w_head),
        .o_nxt_empty (w_nxt_empty),
        .o_nxt_head  (w_nxt_head),
        .o_vld       (w_vld),
        .o_ent       (w_ent)
    );

    // Head state register; it always describes the entry at the queue head
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Retire decision: non-loads go at once, loads wait for their response
    always_comb begin
        w_pop      = 1'b0;
        w_ret_data = w_head.data;
        case (r_state)
            HEAD_RDY:  w_pop = 1'b1;
            HEAD_WAIT: begin
                w_pop      = load_rsp_valid;
                w_ret_data = load_rsp_data;
            end
            default:   w_pop = 1'b0;
        endcase
    end

    // Next state is classified from the head as it stands after this edge
    always_comb begin
        w_state_nxt = EMPTY;
        if (!w_nxt_empty) begin
            w_state_nxt = w_nxt_head.is_load ? HEAD_WAIT : HEAD_RDY;
        end
    end

    // Register-file write port: one-cycle pulse per retire, values held otherwise
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_reg_write <= 1'b0;
            r_rd        <= '0;
            r_data      <= '0;
        end else if (w_pop) begin
            r_reg_write <= w_head.reg_write && (w_head.rd != 5'd0);
            r_rd        <= w_head.rd;
            r_data      <= w_ret_data;
        end else begin
            r_reg_write <= 1'b0;
        end
    end

    // Sticky flag for a load response with no load waiting at the head
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_proto_err <= 1'b0;
        end else if (load_rsp_valid && (r_state != HEAD_WAIT)) begin
            r_proto_err <= 1'b1;
        end
    end

    // Pending-write vector from queued entries only; x0 never reports busy
    always_comb begin
        w_busy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_vld[i] && w_ent[i].reg_write && (w_ent[i].rd != 5'd0)) begin
                w_busy[w_ent[i].rd] = 1'b1;
            end
        end
    end

    assign reg_write      = r_reg_write;
    assign write_reg_num1 = r_rd;
    assign write_data     = r_data;
    assign busy_vec       = w_busy;
    assign proto_err      = r_proto_err;

    // Fields that the control path does not need from these views
    logic w_unused_head;
    assign w_unused_head = ^{w_empty, w_head.is_load, w_nxt_head.rd,
                             w_nxt_head.reg_write, w_nxt_head.data};
    genvar gu;
    generate
        for (gu = 0; gu < DEPTH; gu++) begin : g_unused
            logic w_unused_slot;
            assign w_unused_slot = ^{w_ent[gu].is_load, w_ent[gu].data};
        end
    endgenerate

`ifdef WB_TRACE_EN
    logic [31:0] r_cyc;
    logic [31:0] r_retire_cnt;

    // Cycle stamp and wrapping retire count for trace/debug
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cyc        <= '0;
            r_retire_cnt <= '0;
        end else begin
            r_cyc <= r_cyc + 32'd1;
            if (w_pop) begin
                r_retire_cnt <= r_retire_cnt + 32'd1;
            end
        end
    end

    // Print each write pulse and the moment the protocol error latches
    always @(posedge clk) begin
        if (rst && r_reg_write) begin
            $display("[wb] cyc=%0d write x%0d = %h", r_cyc, r_rd, r_data);
        end
        if (rst && load_rsp_valid && (r_state != HEAD_WAIT) && !r_proto_err) begin
            $display("[wb] cyc=%0d proto_err set", r_cyc);
        end
    end
`endif

endmodule
